// File: rtl/vx_serial_divider.sv
// Radix-2 restoring serial divider: one quotient bit per cycle, valid/ready request and response, tag carried through.
// Optional macro VX_SERIAL_DIV_SHORTCUT_EN: divide-by-zero and |dividend| < |divisor| finish on the accept edge.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for a request, ready_in = 1
// BUSY  | iterating, counter runs W down to 1
// DONE  | result held on outputs until the response handshake
module vx_serial_divider #(
    parameter int W     = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             is_signed,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a;
    logic [W-1:0]     d;
    logic [W:0]       p;
    logic             q_neg;
    logic             r_neg;
    logic [TAG_W-1:0] tag_q;

    logic             accept;
    logic             div_zero;
    logic             short_hit;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_d;
    logic [W:0]       p_shift;
    logic             q_bit;
    logic [W:0]       p_next;
    logic [W-1:0]     a_next;

    assign ready_in  = (state == ST_IDLE) || ((state == ST_DONE) && ready_out);
    assign accept    = valid_in && ready_in;
    assign valid_out = (state == ST_DONE);

    assign div_zero = (divisor == '0);
    assign mag_a    = (is_signed && dividend[W-1]) ? -dividend : dividend;
    assign mag_d    = (is_signed && divisor[W-1])  ? -divisor  : divisor;

`ifdef VX_SERIAL_DIV_SHORTCUT_EN
    // Both cases have a trivial answer: remainder is the raw dividend.
    assign short_hit = div_zero || (mag_a < mag_d);
`else
    assign short_hit = 1'b0;
`endif

    assign p_shift = {p[W-1:0], a[W-1]};
    assign q_bit   = (p_shift >= {1'b0, d});
    assign p_next  = q_bit ? (p_shift - {1'b0, d}) : p_shift;
    assign a_next  = {a[W-2:0], q_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a         <= '0;
            d         <= '0;
            p         <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            tag_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            tag_out   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a     <= mag_a;
                        d     <= mag_d;
                        p     <= '0;
                        // Divide-by-zero keeps the all-ones quotient unsigned-looking.
                        q_neg <= is_signed && (dividend[W-1] ^ divisor[W-1]) && !div_zero;
                        r_neg <= is_signed && dividend[W-1];
                        tag_q <= tag_in;
                        if (short_hit) begin
                            state     <= ST_DONE;
                            cnt       <= '0;
                            quotient  <= div_zero ? '1 : '0;
                            remainder <= dividend;
                            tag_out   <= tag_in;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_W'(W);
                        end
                    end else if ((state == ST_DONE) && ready_out) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    a   <= a_next;
                    p   <= p_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_DONE;
                        quotient  <= q_neg ? -a_next : a_next;
                        remainder <= r_neg ? -p_next[W-1:0] : p_next[W-1:0];
                        tag_out   <= tag_q;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
